// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO that feeds a UART transmitter one byte per frame,
// launching on an idle UART and pacing itself on the UART busy flag.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    input  logic              busy,
    output logic              tx_val,
    output logic [7:0]        tx_data
);

    localparam int TMR_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_END
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic              wr_accept;
    logic              pop;
    logic              tx_val_next;

    // A write is judged against the registered full flag, so a pop in the
    // same cycle never rescues a write into a full FIFO.
    assign wr_accept = wr_en && !full;

    always_comb begin
        count_next = count;
        if (wr_accept && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!wr_accept && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
            // A dropped byte outranks a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        pop         = 1'b0;
        tx_val_next = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !busy) begin
                    pop         = 1'b1;
                    tx_val_next = 1'b1;
                    timer_next  = '0;
                    state_next  = WAIT_START;
                end
            end
            WAIT_START: begin
                // If the UART never acknowledges, the byte is abandoned.
                if (busy) begin
                    state_next = WAIT_END;
                end else begin
                    timer_next = timer + TMR_ONE;
                    if (timer_next == TMR_LIMIT) begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT_END: begin
                if (!busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            tx_val  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            tx_val <= tx_val_next;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a byte queue reference model plus a simple
// UART busy model, with one task per scenario.
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;
    logic              busy;
    logic              tx_val;
    logic [7:0]        tx_data;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .clr_ovf(clr_ovf),
        .busy(busy),
        .tx_val(tx_val),
        .tx_data(tx_data)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         model_ovf;
    bit         busy_hold;
    bit         busy_auto;
    int         busy_len;
    int         busy_cnt;
    int         rise_in;
    int         max_count;
    int         cyc = 0;

    // One clock: drive inputs, advance the UART busy model, then update the
    // byte queue model from what happened at the edge.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic clr);
        bit acc;
        if (rise_in > 0) begin
            rise_in--;
            if (rise_in == 0) busy_cnt = busy_len;
        end
        busy = busy_hold || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        wr_en   = we;
        wr_data = wd;
        clr_ovf = clr;
        acc = we && (model_q.size() < DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (tx_val) begin
            got.push_back(tx_data);
            if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
            else exp_q.push_back(8'hxx);
            if (busy_auto) rise_in = 2;
        end
        if (acc) model_q.push_back(wd);
        if (we && !acc) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        if (int'(count) > max_count) max_count = int'(count);
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fresh();
        busy_hold = 1'b0;
        busy_auto = 1'b1;
        busy_len  = 10;
        busy_cnt  = 0;
        rise_in   = 0;
        busy      = 1'b0;
        apply_reset();
        release_reset();
        got.delete();
        exp_q.delete();
        max_count = 0;
    endtask

    task automatic test_reset();
        fresh();
        apply_reset();
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (tx_val !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_val: got %b expected 0", tx_val); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        release_reset();
        repeat (5) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 0) begin n_fail++; $display("[TB] FAIL reset_idle_launch: got %0d launches expected 0", got.size()); end
    endtask

    task automatic test_single();
        fresh();
        cycle(1'b1, 8'h55, 1'b0);
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("[TB] FAIL single_count1: got %0d expected 1", count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("[TB] FAIL single_empty0: got %b expected 0", empty); end
        n_checks++; if (tx_val !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_val: got %b expected 0", tx_val); end
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (tx_val !== 1'b1) begin n_fail++; $display("[TB] FAIL single_tx_val: got %b expected 1", tx_val); end
        n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("[TB] FAIL single_tx_data: got %h expected 55", tx_data); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL single_count0: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL single_empty1: got %b expected 1", empty); end
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (tx_val !== 1'b0) begin n_fail++; $display("[TB] FAIL single_pulse_width: got %b expected 0", tx_val); end
        repeat (25) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 1) begin n_fail++; $display("[TB] FAIL single_launches: got %0d expected 1", got.size()); end
        n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("[TB] FAIL single_data_hold: got %h expected 55", tx_data); end
    endtask

    task automatic test_burst();
        fresh();
        busy_hold = 1'b1;
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_full: got %b expected 1", full); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("[TB] FAIL burst_count: got %0d expected 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_ovf_early: got %b expected 0", overflow); end
        cycle(1'b1, 8'hAA, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_ovf: got %b expected 1", overflow); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("[TB] FAIL burst_drop_count: got %0d expected 16", count); end
        busy_hold = 1'b0;
        for (int i = 0; i < 600 && got.size() < 16; i++) cycle(1'b0, 8'h00, 1'b0);
        repeat (30) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 16) begin n_fail++; $display("[TB] FAIL burst_launches: got %0d expected 16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_checks++; if (got[i] !== 8'(i + 1)) begin n_fail++; $display("[TB] FAIL burst_order[%0d]: got %h expected %h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_full_pop();
        fresh();
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0);
        busy_hold = 1'b0;
        cycle(1'b1, 8'hEE, 1'b0);
        n_checks++; if (tx_val !== 1'b1) begin n_fail++; $display("[TB] FAIL fullpop_launch: got %b expected 1", tx_val); end
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("[TB] FAIL fullpop_count: got %0d expected 15", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL fullpop_ovf: got %b expected 1", overflow); end
        cycle(1'b1, 8'($urandom), 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL refill_full: got %b expected 1", full); end
        cycle(1'b1, 8'hEF, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL set_wins_ovf: got %b expected 1", overflow); end
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 500 && got.size() < 17; i++) cycle(1'b0, 8'h00, 1'b0);
        repeat (20) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 17) begin n_fail++; $display("[TB] FAIL fullpop_launches: got %0d expected 17", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL fullpop_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (overflow !== model_ovf) begin n_fail++; $display("[TB] FAIL fullpop_ovf_end: got %b expected %b", overflow, model_ovf); end
    endtask

    task automatic test_timeout();
        int t1;
        int t2;
        fresh();
        busy_auto = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h3D, 1'b0);
        for (int i = 0; i < 10 && got.size() < 1; i++) cycle(1'b0, 8'h00, 1'b0);
        t1 = cyc;
        for (int i = 0; i < 400 && got.size() < 2; i++) cycle(1'b0, 8'h00, 1'b0);
        t2 = cyc;
        n_checks++; if (got.size() != 2) begin n_fail++; $display("[TB] FAIL timeout_launches: got %0d expected 2", got.size()); end
        // 255 cycles in WAIT_START, then one IDLE cycle before the next launch.
        n_checks++; if (t2 - t1 != BUSY_TIMEOUT + 1) begin n_fail++; $display("[TB] FAIL timeout_gap: got %0d expected %0d", t2 - t1, BUSY_TIMEOUT + 1); end
        if (got.size() >= 2) begin
            n_checks++; if (got[0] !== 8'h3C) begin n_fail++; $display("[TB] FAIL timeout_first: got %h expected 3c", got[0]); end
            n_checks++; if (got[1] !== 8'h3D) begin n_fail++; $display("[TB] FAIL timeout_second: got %h expected 3d", got[1]); end
        end
        repeat (300) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 2) begin n_fail++; $display("[TB] FAIL timeout_no_resend: got %0d expected 2", got.size()); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL timeout_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        fresh();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b0);
        apply_reset();
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_empty: got %b expected 1", empty); end
        n_checks++; if (tx_val !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_tx_val: got %b expected 0", tx_val); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_tx_data: got %h expected 00", tx_data); end
        release_reset();
        repeat (30) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 1) begin n_fail++; $display("[TB] FAIL mid_no_launch: got %0d expected 1", got.size()); end
        cycle(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 40 && got.size() < 2; i++) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 2) begin n_fail++; $display("[TB] FAIL mid_relaunch: got %0d expected 2", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL mid_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        int  next_byte;
        bit  we;
        fresh();
        next_byte = 0;
        for (int i = 0; i < 3000 && got.size() < 40; i++) begin
            we = (next_byte < 40) && ($urandom_range(0, 2) != 0) && (model_q.size() < DEPTH);
            busy_len = $urandom_range(1, 5);
            cycle(we, 8'(next_byte), 1'b0);
            if (we) next_byte++;
        end
        repeat (10) cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (got.size() != 40) begin n_fail++; $display("[TB] FAIL wrap_launches: got %0d expected 40", got.size()); end
        for (int i = 0; i < got.size() && i < 40; i++) begin
            n_checks++; if (got[i] !== 8'(i)) begin n_fail++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", i, got[i], 8'(i)); end
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL wrap_model[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (max_count > DEPTH) begin n_fail++; $display("[TB] FAIL wrap_max_count: got %0d expected <= %0d", max_count, DEPTH); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_ovf: got %b expected 0", overflow); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        clr_ovf   = 1'b0;
        busy      = 1'b0;
        busy_hold = 1'b0;
        busy_auto = 1'b1;
        busy_len  = 10;
        busy_cnt  = 0;
        rise_in   = 0;
        max_count = 0;
        model_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
